// File: rtl/booth_mul_seq.sv
// booth_mul_seq: sequential signed 32x32->64 radix-2 Booth multiplier driving an external combinational add/sub adder
//   clk             in   1   rising-edge clock
//   rst             in   1   synchronous active-high reset
//   start_i         in   1   request a multiply (sampled when not busy)
//   multiplicand_i  in  32   signed operand M
//   multiplier_i    in  32   signed operand Q
//   busy_o          out  1   high while iterating
//   done_o          out  1   one-cycle pulse when product_o becomes valid
//   product_o       out 64   signed product, held until the next accepted start
//   add_sub_o       out  1   adder sub select
//   add_a_o         out 32   adder inA
//   add_b_o         out 32   adder inB
//   add_result_i    in  32   adder sum
//   add_overflow_i  in   1   adder signed overflow
//   Optional: define MUL_ZERO_BYPASS_EN to finish immediately with product 0 on a zero operand.
module booth_mul_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_i,
   input  logic [31:0] multiplicand_i,
   input  logic [31:0] multiplier_i,
   output logic        busy_o,
   output logic        done_o,
   output logic [63:0] product_o,
   output logic        add_sub_o,
   output logic [31:0] add_a_o,
   output logic [31:0] add_b_o,
   input  logic [31:0] add_result_i,
   input  logic        add_overflow_i
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t      state_q, state_d;
   logic [31:0] a_q, a_d, q_q, q_d, m_q, m_d;
   logic        qm1_q, qm1_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [63:0] prod_q, prod_d;
   logic        run, arith, sgn, zero_op;
   logic [31:0] s_val, a_sh, q_sh;
`ifdef MUL_ZERO_BYPASS_EN
   assign zero_op = (multiplicand_i == 32'd0) || (multiplier_i == 32'd0);
`else
   assign zero_op = 1'b0;
`endif
   always_comb begin
      run       = state_q == RUN;
      arith     = run && (q_q[0] ^ qm1_q);
      add_sub_o = run && q_q[0] && !qm1_q;
      add_a_o   = run ? a_q : 32'd0;
      add_b_o   = arith ? m_q : 32'd0;
      s_val     = arith ? add_result_i : a_q;
      // the overflow flag recovers the true sign of the 33-bit sum
      sgn       = arith ? add_result_i[31] ^ add_overflow_i : a_q[31];
      a_sh      = {sgn, s_val[31:1]};
      q_sh      = {s_val[0], q_q[31:1]};
      state_d   = state_q;
      a_d       = a_q;
      q_d       = q_q;
      qm1_d     = qm1_q;
      m_d       = m_q;
      cnt_d     = cnt_q;
      prod_d    = prod_q;
      if (run) begin
         a_d   = a_sh;
         q_d   = q_sh;
         qm1_d = q_q[0];
         cnt_d = cnt_q + 6'd1;
         if (cnt_q == 6'd31) begin
            state_d = DONE;
            prod_d  = {a_sh, q_sh};
         end
      end else if (start_i) begin
         a_d     = 32'd0;
         q_d     = multiplier_i;
         qm1_d   = 1'b0;
         m_d     = multiplicand_i;
         cnt_d   = 6'd0;
         state_d = zero_op ? DONE : RUN;
         prod_d  = zero_op ? 64'd0 : prod_q;
      end else begin
         state_d = IDLE;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= 32'd0;
         q_q     <= 32'd0;
         qm1_q   <= 1'b0;
         m_q     <= 32'd0;
         cnt_q   <= 6'd0;
         prod_q  <= 64'd0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         q_q     <= q_d;
         qm1_q   <= qm1_d;
         m_q     <= m_d;
         cnt_q   <= cnt_d;
         prod_q  <= prod_d;
      end
   end
   assign busy_o    = state_q == RUN;
   assign done_o    = state_q == DONE;
   assign product_o = prod_q;
endmodule
